// File: rtl/mips_mux_pkg.sv
// Shared constants and types for the N-way output-registered mux/arbiter.
package mips_mux_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N     = 4;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/muxn_arb_if.sv
// Handshake bundle between the N input channels, the select controls and the output register.
interface muxn_arb_if
  import mips_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int SW    = $clog2(N)
);

  mode_e              i_mode;
  logic [SW-1:0]      i_sel;
  logic [N-1:0]       i_inValid;
  logic [N*WIDTH-1:0] i_inData;
  logic [N-1:0]       o_inReady;
  logic               o_outValid;
  logic [WIDTH-1:0]   o_outData;
  logic [SW-1:0]      o_outSel;
  logic               i_outReady;

  modport slave (
    input  i_mode, i_sel, i_inValid, i_inData, i_outReady,
    output o_inReady, o_outValid, o_outData, o_outSel
  );

  modport master (
    output i_mode, i_sel, i_inValid, i_inData, i_outReady,
    input  o_inReady, o_outValid, o_outData, o_outSel
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting channel at or after ptr, wrapping modulo N.
module rr_arbiter
  import mips_mux_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [SW-1:0] o_grant,
  output logic          o_grantValid
);

  // Scan from the farthest offset down so the nearest requester to ptr wins last.
  always_comb begin
    o_grant      = '0;
    o_grantValid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_grant      = SW'((int'(i_ptr) + k) % N);
        o_grantValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxn_arb.sv
// N-channel mux with a single output register; channel chosen by fixed select or round-robin.
module muxn_arb
  import mips_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int SW    = $clog2(N)
) (
  input logic       clk,
  input logic       rst,
  muxn_arb_if.slave bus
);

  logic [SW-1:0]    r_ptr;
  logic             r_outValid;
  logic [WIDTH-1:0] r_outData;
  logic [SW-1:0]    r_outSel;

  logic [SW-1:0]    w_rrGrant;
  logic             w_rrValid;
  logic [SW-1:0]    w_grant;
  logic             w_grantValid;
  logic             w_canLoad;
  logic             w_accept;
  logic [SW-1:0]    w_nextPtr;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_rrArbiter (
    .i_req        (bus.i_inValid),
    .i_ptr        (r_ptr),
    .o_grant      (w_rrGrant),
    .o_grantValid (w_rrValid)
  );

  // Mode switches the grant source immediately; an out-of-range sel simply yields no grant.
  always_comb begin
    w_grant      = '0;
    w_grantValid = 1'b0;
    if (bus.i_mode == MODE_RR) begin
      w_grant      = w_rrGrant;
      w_grantValid = w_rrValid;
    end else if (int'(bus.i_sel) < N) begin
      w_grant      = bus.i_sel;
      w_grantValid = bus.i_inValid[bus.i_sel];
    end
  end

  assign w_canLoad = ~r_outValid | bus.i_outReady;
  assign w_accept  = rst & w_grantValid & w_canLoad;
  assign w_nextPtr = (w_grant == SW'(N - 1)) ? '0 : w_grant + SW'(1);

  assign bus.o_inReady  = w_accept ? (N'(1) << w_grant) : '0;
  assign bus.o_outValid = r_outValid;
  assign bus.o_outData  = r_outData;
  assign bus.o_outSel   = r_outSel;

  // A reload on accept takes priority over the drain, giving one word per cycle when streaming.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSel   <= '0;
      r_ptr      <= '0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_outData  <= bus.i_inData[int'(w_grant) * WIDTH +: WIDTH];
      r_outSel   <= w_grant;
      if (bus.i_mode == MODE_RR) begin
        r_ptr <= w_nextPtr;
      end
    end else if (bus.i_outReady) begin
      r_outValid <= 1'b0;
    end
  end

endmodule
